ram_mem_ctrl: RTL

Sequential memory controller sitting directly upstream of the 8-bit on-board RAM. It accepts byte, half-word and word load/store requests from the CPU core and serialises each one into little-endian byte accesses on the RAM port. It pipelines around the RAM's one-cycle synchronous read latency and returns one response pulse per request.

---
 rtl/ram_mem_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_mem_ctrl.sv
// Byte-serialising load/store controller in front of an 8-bit synchronous RAM.
// Optional alignment checking is enabled by defining MEM_CTRL_ALIGN_CHK_EN.
module ram_mem_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  ram_en,
    output logic                  ram_r_nw,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_d_out,
    input  logic [7:0]            ram_d_in
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_LAST
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_last;
    logic [1:0]            r_k;
    logic                  r_signed;
    logic [31:0]           r_wdata;
    logic [31:0]           r_asm;
    logic [31:0]           r_rdata;
    logic                  r_resp_valid;
    logic                  r_ram_en;
    logic                  r_ram_r_nw;
    logic [ADDR_WIDTH-1:0] r_ram_a;
    logic [7:0]            r_ram_d_out;

    logic                  w_accept;
    logic [1:0]            w_k_next;
    logic [1:0]            w_cap_idx;
    logic [ADDR_WIDTH-1:0] w_a_next;
    logic [31:0]           w_asm_next;

    // Index of the final byte: 0 for byte, 1 for half, 3 for word (and reserved).
    function automatic logic [1:0] size_to_last(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [1:0] last,
                                           input logic sgn,
                                           input logic [31:0] raw);
        case (last)
            2'd0:    return {{24{sgn & raw[7]}}, raw[7:0]};
            2'd1:    return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] data,
                                             input logic [1:0] idx);
        logic [31:0] sh;
        sh = data >> {idx, 3'b000};
        return sh[7:0];
    endfunction

    assign req_ready  = (r_state == ST_IDLE) && !rst_in;
    assign w_accept   = req_valid && req_ready;
    assign w_k_next   = r_k + 2'd1;
    assign w_a_next   = r_addr + ADDR_WIDTH'(w_k_next);

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign ram_en     = r_ram_en;
    assign ram_r_nw   = r_ram_r_nw;
    assign ram_a      = r_ram_a;
    assign ram_d_out  = r_ram_d_out;

    // RAM data lags the address by one cycle, so READ captures the previous
    // byte and LAST captures the final one.
    always_comb begin
        w_cap_idx  = (r_state == ST_LAST) ? r_k : (r_k - 2'd1);
        w_asm_next = r_asm;
        w_asm_next[{w_cap_idx, 3'b000} +: 8] = ram_d_in;
    end

`ifdef MEM_CTRL_ALIGN_CHK_EN
    logic r_resp_err;
    logic w_misaligned;

    assign w_misaligned = (req_size == 2'b01) ? req_addr[0] :
                          (req_size[1]        ? (req_addr[1:0] != 2'b00) : 1'b0);
    assign resp_err     = r_resp_err;
`else
    assign resp_err     = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_last       <= 2'd0;
            r_k          <= 2'd0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_asm        <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_r_nw   <= 1'b1;
            r_ram_a      <= '0;
            r_ram_d_out  <= '0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
            r_resp_err   <= 1'b0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_last   <= size_to_last(req_size);
                        r_signed <= req_signed;
                        r_wdata  <= req_wdata;
                        r_k      <= 2'd0;
                        r_asm    <= '0;
`ifdef MEM_CTRL_ALIGN_CHK_EN
                        if (w_misaligned) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_rdata      <= '0;
                        end else
`endif
                        begin
                            r_ram_en <= 1'b1;
                            r_ram_a  <= req_addr;
                            if (req_we) begin
                                r_ram_r_nw  <= 1'b0;
                                r_ram_d_out <= req_wdata[7:0];
                                r_state     <= ST_WRITE;
                            end else begin
                                r_ram_r_nw  <= 1'b1;
                                r_state     <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (r_k != 2'd0) begin
                        r_asm <= w_asm_next;
                    end
                    if (r_k == r_last) begin
                        r_state <= ST_LAST;
                    end else begin
                        r_k     <= w_k_next;
                        r_ram_a <= w_a_next;
                    end
                end
                ST_LAST: begin
                    r_asm        <= w_asm_next;
                    r_rdata      <= extend(r_last, r_signed, w_asm_next);
                    r_ram_en     <= 1'b0;
                    r_resp_valid <= 1'b1;
`ifdef MEM_CTRL_ALIGN_CHK_EN
                    r_resp_err   <= 1'b0;
`endif
                    r_state      <= ST_IDLE;
                end
                ST_WRITE: begin
                    if (r_k == r_last) begin
                        r_ram_en     <= 1'b0;
                        r_ram_r_nw   <= 1'b1;
                        r_resp_valid <= 1'b1;
`ifdef MEM_CTRL_ALIGN_CHK_EN
                        r_resp_err   <= 1'b0;
`endif
                        r_state      <= ST_IDLE;
                    end else begin
                        r_k         <= w_k_next;
                        r_ram_a     <= w_a_next;
                        r_ram_d_out <= pick_byte(r_wdata, w_k_next);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
